// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the word-serial wide adder sequencer.
package wide_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_WORDS = 4;
  localparam int DEF_TOTAL = DEF_WIDTH * DEF_WORDS;

  // Index width; a single-word build still needs a 1-bit index.
  function automatic int idx_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/word_select_mux.sv
// WORDS:1 selector picking one WIDTH-bit word out of a packed multi-word vector.
module word_select_mux
  import wide_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS,
  parameter int IDXW  = idx_bits(DEF_WORDS)
) (
  input  logic [WIDTH*WORDS-1:0] data,
  input  logic [IDXW-1:0]        sel,
  output logic [WIDTH-1:0]       word
);

  logic [WIDTH-1:0] words [WORDS];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
    assign words[gi] = data[gi*WIDTH +: WIDTH];
  end

  // Out-of-range indices (non power-of-two WORDS) select zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (sel == IDXW'(i)) word = words[i];
    end
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Drives one external WIDTH-bit adder word by word, LSW first, to build a
// WIDTH*WORDS-bit add or subtract with the carry held in a register.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_s,
  input  logic                   add_cout
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int IDXW  = idx_bits(WORDS);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [TOTAL-1:0] a_q, a_d;
  logic [TOTAL-1:0] b_q, b_d;
  logic [TOTAL-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             run;

  word_select_mux #(.WIDTH(WIDTH), .WORDS(WORDS), .IDXW(IDXW)) u_sel_a (
    .data (a_q),
    .sel  (idx_q),
    .word (a_word)
  );

  word_select_mux #(.WIDTH(WIDTH), .WORDS(WORDS), .IDXW(IDXW)) u_sel_b (
    .data (b_q),
    .sel  (idx_q),
    .word (b_word)
  );

  // Adder inputs are pure functions of registers, parked at zero outside RUN.
  assign run     = (state_q == ST_RUN);
  assign add_a   = run ? a_word : '0;
  assign add_b   = run ? b_word : '0;
  assign add_cin = run & carry_q;

  assign busy = run;
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = add_cout;
          // Overflow when the operand signs agree but the result sign differs.
          ovf_d   = (a_q[TOTAL-1] == b_q[TOTAL-1]) && (add_s[WIDTH-1] != a_q[TOTAL-1]);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench: wide_add_sequencer driving a behavioural 32-bit adder, 4 words.
module tb_wide_add_sequencer;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int TOTAL = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [TOTAL-1:0] op_a;
  logic [TOTAL-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [TOTAL-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;

  int checks = 0;
  int errors = 0;

  // Results captured by run_op
  logic [TOTAL-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  int               r_lat;
  int               r_busy;
  logic [TOTAL-1:0] r_sum_at_accept;
  logic [WIDTH-1:0] r_add_a0;
  logic [WIDTH-1:0] r_add_b0;
  logic             r_add_cin0;
  logic [WIDTH-1:0] r_done_add_a;
  logic [WIDTH-1:0] r_done_add_b;
  logic             r_done_add_cin;

  always #5 clk = ~clk;

  // Shared ripple adder lives outside the sequencer.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE or DONE and follow it to its DONE cycle.
  // ign_at > 0 pulses a junk start in that RUN cycle.
  task automatic run_op(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                        input logic c, input logic s, input int ign_at);
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    r_sum_at_accept = sum;
    r_add_a0   = add_a;
    r_add_b0   = add_b;
    r_add_cin0 = add_cin;
    r_busy = 0;
    r_lat  = 99;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin
        r_lat = n;
        break;
      end
      if (busy) r_busy++;
      if (n == ign_at) begin
        op_a  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        op_b  = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
        sub   = 1'b1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    r_sum  = sum;
    r_cout = cout;
    r_ovf  = ovf;
    r_done_add_a   = add_a;
    r_done_add_b   = add_b;
    r_done_add_cin = add_cin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    sub = 1'b0;
    cin = 1'b0;
    op_a = 128'd9;
    op_b = 128'd9;
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf});
    end
    checks++;
    if (sum !== '0) begin
      errors++;
      $display("FAIL reset_sum got %h want 0", sum);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_adder got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy/done=%b want 00", {busy, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic_add();
    run_op(128'd1, 128'd2, 1'b0, 1'b0, 0);
    $display("add 1+2: sum=%h cout=%b ovf=%b lat=%0d busy=%0d", r_sum, r_cout, r_ovf, r_lat, r_busy);
    checks++;
    if (r_sum !== 128'd3 || r_cout !== 1'b0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_add got sum=%h cout=%b ovf=%b want 3/0/0", r_sum, r_cout, r_ovf);
    end
    checks++;
    if (r_lat !== 5) begin
      errors++;
      $display("FAIL basic_latency got %0d want 5", r_lat);
    end
    checks++;
    if (r_busy !== 4) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 4", r_busy);
    end
    checks++;
    if (r_add_a0 !== 32'd1 || r_add_b0 !== 32'd2 || r_add_cin0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_word got a=%h b=%h cin=%b want 1/2/0", r_add_a0, r_add_b0, r_add_cin0);
    end
    checks++;
    if ({r_done_add_a, r_done_add_b, r_done_add_cin} !== '0) begin
      errors++;
      $display("FAIL done_adder_idle got a=%h b=%h cin=%b want 0", r_done_add_a, r_done_add_b, r_done_add_cin);
    end
    tick();
    checks++;
    if (done !== 1'b0 || sum !== 128'd3) begin
      errors++;
      $display("FAIL done_pulse_hold got done=%b sum=%h want 0/3", done, sum);
    end
  endtask

  task automatic test_carry_ripple();
    run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFC, 128'd4, 1'b0, 1'b0, 0);
    $display("ripple: sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if (r_sum !== 128'h00000001_00000000_00000000_00000000 || r_cout !== 1'b0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_ripple got sum=%h cout=%b ovf=%b want 00000001_0..0/0/0", r_sum, r_cout, r_ovf);
    end
    tick();
  endtask

  task automatic test_boundaries();
    run_op({TOTAL{1'b1}}, 128'd0, 1'b1, 1'b0, 0);
    $display("ones+0+cin: sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if (r_sum !== '0 || r_cout !== 1'b1 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_cin got sum=%h cout=%b ovf=%b want 0/1/0", r_sum, r_cout, r_ovf);
    end
    checks++;
    if (r_add_cin0 !== 1'b1) begin
      errors++;
      $display("FAIL cin_first_word got %b want 1", r_add_cin0);
    end
    tick();
    run_op(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0, 0);
    $display("maxpos+1: sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if (r_sum !== 128'h80000000_00000000_00000000_00000000 || r_cout !== 1'b0 || r_ovf !== 1'b1) begin
      errors++;
      $display("FAIL signed_ovf got sum=%h cout=%b ovf=%b want 80..0/0/1", r_sum, r_cout, r_ovf);
    end
    tick();
  endtask

  task automatic test_subtract();
    run_op(128'd5, 128'd7, 1'b0, 1'b1, 0);
    $display("sub 5-7: sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if (r_sum !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE || r_cout !== 1'b0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow got sum=%h cout=%b ovf=%b want F..FE/0/0", r_sum, r_cout, r_ovf);
    end
    checks++;
    if (r_add_b0 !== 32'hFFFFFFF8 || r_add_cin0 !== 1'b1) begin
      errors++;
      $display("FAIL sub_adder_inputs got b=%h cin=%b want FFFFFFF8/1", r_add_b0, r_add_cin0);
    end
    // Back-to-back: DONE cycle accepts the next request directly.
    run_op(128'd7, 128'd5, 1'b0, 1'b1, 0);
    $display("sub 7-5: sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if (r_sum !== 128'd2 || r_cout !== 1'b1 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_no_borrow got sum=%h cout=%b ovf=%b want 2/1/0", r_sum, r_cout, r_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    run_op(128'h1234, 128'h10, 1'b0, 1'b0, 2);
    $display("ignored start: sum=%h lat=%0d", r_sum, r_lat);
    checks++;
    if (r_sum !== 128'h1244 || r_lat !== 5) begin
      errors++;
      $display("FAIL start_in_run got sum=%h lat=%0d want 1244/5", r_sum, r_lat);
    end
    run_op(128'h00000001_00000000_00000000_00000000, 128'd1, 1'b0, 1'b1, 0);
    $display("b2b: sum=%h cout=%b lat=%0d", r_sum, r_cout, r_lat);
    checks++;
    if (r_sum_at_accept !== '0) begin
      errors++;
      $display("FAIL b2b_accept_clear got sum=%h want 0", r_sum_at_accept);
    end
    checks++;
    if (r_sum !== 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF || r_cout !== 1'b1 || r_lat !== 5) begin
      errors++;
      $display("FAIL b2b_result got sum=%h cout=%b lat=%0d want 0_F..F/1/5", r_sum, r_cout, r_lat);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int seen_done;
    op_a  = 128'h11111111_22222222_33333333_44444444;
    op_b  = 128'h1;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid reset: busy=%b done=%b sum=%h", busy, done, sum);
    checks++;
    if ({busy, done} !== 2'b00 || sum !== '0 || {add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b sum=%h a=%h b=%h want all 0", busy, done, sum, add_a, add_b);
    end
    seen_done = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) seen_done++;
      tick();
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", seen_done);
    end
    run_op(128'hFFFFFFFF, 128'd1, 1'b0, 1'b0, 0);
    $display("after reset: sum=%h cout=%b lat=%0d", r_sum, r_cout, r_lat);
    checks++;
    if (r_sum !== 128'h1_00000000 || r_cout !== 1'b0 || r_lat !== 5) begin
      errors++;
      $display("FAIL post_reset_op got sum=%h cout=%b lat=%0d want 100000000/0/5", r_sum, r_cout, r_lat);
    end
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_boundaries();
    test_subtract();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Sequences one external WIDTH-bit ripple carry adder over a WORDS-word operand pair to form a WIDTH*WORDS-bit add or subtract. Processing runs least-significant word first, one word per cycle, with the carry fed back through a register. Sits between a requester (start/done handshake) and the shared adder instance. The adder stays purely combinational and outside this block.

Parameters:
WIDTH, 32, word width of the external adder
WORDS, 4, number of words per operand (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, cin forced 1); sampled with start
op_a  input  WIDTH*WORDS  operand A; sampled with start
op_b  input  WIDTH*WORDS  operand B; sampled with start
cin  input  1  carry-in for add; sampled with start; ignored when sub=1
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
sum  output  WIDTH*WORDS  registered result; held until next accepted start
cout  output  1  final carry (sub: 1 = no borrow)
ovf  output  1  two's-complement overflow of full-width result
add_a  output  WIDTH  word to adder A input
add_b  output  WIDTH  word to adder B input (already inverted when sub)
add_cin  output  1  adder carry-in
add_s  input  WIDTH  adder sum
add_cout  input  1  adder carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE
  - busy = done = cout = ovf = 0
  - sum = 0, word index = 0, carry register = 0
  - add_a = add_b = 0, add_cin = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch op_a, op_b (op_b inverted when sub=1).
  - Load carry register with (sub ? 1 : cin); set idx = 0; clear sum; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Drive add_a = A word[idx], add_b = B' word[idx], add_cin = carry register. These come from registers only; nothing depends combinationally on inputs.
  - Each edge: sum word[idx] <= add_s, carry <= add_cout, idx++.
  - On the edge capturing idx = WORDS-1: cout <= add_cout; ovf <= (a_msb == b'_msb) && (add_s msb != a_msb); go to DONE.
  - start is ignored in RUN; no queuing.
- DONE:
  - done = 1 for exactly this cycle; add_* driven 0.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operations, 1 idle cycle between bursts.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0, words captured at E1..E_WORDS, done high in the cycle after E_WORDS, i.e. WORDS+1 cycles after the start edge. Throughput is one operation per WORDS+1 cycles.
- add_a, add_b and add_cin are 0 outside RUN so the shared adder idles at a known value.
- Widths:
  - idx is clog2(WORDS) bits; it wraps only through the reset to 0 on accept.
  - The result is exactly WIDTH*WORDS bits; no truncation beyond cout.
- Reset mid-RUN: the next edge goes to IDLE, sum is cleared, done is not pulsed, and any partial result is discarded.
- rst and start in the same cycle: rst wins.
- sum, cout and ovf are stable from done until the next accepted start, which clears them on the accept edge.

Decomposition:
- Shared package wide_add_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - default WIDTH/WORDS constants
  - the localparam for total width
- One natural sub-module, word_select_mux: a parameterised WORDS:1 WIDTH-bit selector indexed by idx, instantiated for A and B.
- The ripple carry adder is instantiated at the parent level, not inside this block.

Test Plan:
All scenarios use WIDTH=32, WORDS=4, with a real ripple carry adder wired to the add_* ports.
1. op_a=1, op_b=2, cin=0, sub=0 -> sum=3, cout=0, ovf=0; done exactly 5 cycles after the start edge; busy high for 4 cycles.
2. op_a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFC, op_b=4 -> sum=0x00000001_00000000_00000000_00000000, cout=0 (carry ripples across 3 word boundaries).
3. op_a=all ones, op_b=0, cin=1 -> sum=0, cout=1, ovf=0. Also op_a=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, op_b=1 -> ovf=1.
4. sub=1, op_a=5, op_b=7 -> sum=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, cout=0. Then sub=1, op_a=7, op_b=5 -> sum=2, cout=1.
5. Start pulsed again in a RUN cycle with different operands -> ignored, first result unchanged. Start held through the DONE cycle -> second operation accepted, done pulses 5 cycles later.
6. rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, add_a=add_b=0. A fresh start then completes normally.
